// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and pipeline-register payload types.
// No logic; types only.
// No flow control; consumers define their own handshakes.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between fetch and decode with bubble/hold/capture controls.
// Latency: 1 cycle from d to q.
// Backpressure: hold freezes q; bubble overrides hold; idle controls also hold.
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   capture,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    localparam if_id_t BUBBLE_WORD = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= BUBBLE_WORD;
        end else if (bubble) begin
            q <= BUBBLE_WORD;
        end else if (hold) begin
            q <= q;
        end else if (capture) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction fetch: PC, next-PC mux, sticky fetch fault, IF/ID register.
// Latency: PC to IF/ID in 1 cycle; a redirect shows its target in IF/ID 2 cycles later.
// Backpressure: Stall holds PC and IF/ID; Branch_taken still redirects under Stall.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_BYTES = 160
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    output logic [31:0] Read_address,
    input  logic [31:0] Instruction,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC_plus4,
    output logic        IF_ID_Valid,
    output logic        Fetch_fault
);

    localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - WORD_BYTES);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic        illegal_pc;
    logic        fault_q;
    logic        fault_set;
    logic        bubble_en;
    logic        capture_en;
    if_id_t      if_id_d;
    if_id_t      if_id_q;

    assign pc_plus4   = pc_q + 32'(WORD_BYTES);
    assign illegal_pc = (pc_q[1:0] != 2'b00) || (pc_q > LAST_ADDR);

    // A fault is only recorded when the illegal PC would really be captured.
    assign fault_set  = illegal_pc && !Stall && !Flush && !Branch_taken;

    always_comb begin
        pc_d = pc_plus4;
        if (Branch_taken) begin
            pc_d = Branch_target;
        end else if (Stall || fault_q || illegal_pc) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_q | fault_set;
        end
    end

    assign bubble_en  = Branch_taken || Flush || (fault_q && !Stall);
    assign capture_en = !Stall && !bubble_en;

    always_comb begin
        if_id_d.instr    = illegal_pc ? NOP_INSTR : Instruction;
        if_id_d.pc_plus4 = pc_plus4;
        if_id_d.valid    = !illegal_pc;
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .capture (capture_en),
        .hold    (Stall),
        .bubble  (bubble_en),
        .d       (if_id_d),
        .q       (if_id_q)
    );

    assign Read_address      = pc_q;
    assign IF_ID_Instruction = if_id_q.instr;
    assign IF_ID_PC_plus4    = if_id_q.pc_plus4;
    assign IF_ID_Valid       = if_id_q.valid;
    assign Fetch_fault       = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stall, branch, range and alignment faults.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Stall;
    logic        Flush;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic [31:0] Read_address;
    logic [31:0] Instruction;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PC_plus4;
    logic        IF_ID_Valid;
    logic        Fetch_fault;

    logic [31:0] mem [64];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign Instruction = mem[Read_address[7:2]];

    if_stage #(.RESET_PC(32'h0), .IMEM_BYTES(160)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .Stall             (Stall),
        .Flush             (Flush),
        .Branch_taken      (Branch_taken),
        .Branch_target     (Branch_target),
        .Read_address      (Read_address),
        .Instruction       (Instruction),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PC_plus4    (IF_ID_PC_plus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .Fetch_fault       (Fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                            input logic v, input logic [31:0] ra, input logic f);
        chk({tag, ".instr"}, IF_ID_Instruction, ins);
        chk({tag, ".pc4"},   IF_ID_PC_plus4,    p4);
        chk({tag, ".valid"}, 32'(IF_ID_Valid),  32'(v));
        chk({tag, ".ra"},    Read_address,      ra);
        chk({tag, ".fault"}, 32'(Fetch_fault),  32'(f));
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_000A;

        reset_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
        Branch_taken = 1'b0; Branch_target = 32'h0;
        #12;
        chk_ifid("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        reset_n = 1'b1;

        // Sequential fetch from reset
        step(); chk_ifid("seq1", 32'h2001_0005, 32'd4, 1'b1, 32'd4, 1'b0);
        step(); chk_ifid("seq2", 32'h2002_000A, 32'd8, 1'b1, 32'd8, 1'b0);

        // Stall for two cycles at PC=8
        Stall = 1'b1;
        step(); chk_ifid("stall1", 32'h2002_000A, 32'd8, 1'b1, 32'd8, 1'b0);
        step(); chk_ifid("stall2", 32'h2002_000A, 32'd8, 1'b1, 32'd8, 1'b0);
        Stall = 1'b0;
        step(); chk_ifid("unstall", 32'hA000_0002, 32'd12, 1'b1, 32'd12, 1'b0);
        step(); chk_ifid("seq16", 32'hA000_0003, 32'd16, 1'b1, 32'd16, 1'b0);

        // Branch at PC=16 to 0x40
        Branch_taken = 1'b1; Branch_target = 32'h40;
        step(); chk_ifid("br_bubble", 32'h0, 32'h0, 1'b0, 32'h40, 1'b0);
        Branch_taken = 1'b0;
        step(); chk_ifid("br_target", 32'hA000_0010, 32'h44, 1'b1, 32'h44, 1'b0);

        // Run off the end of memory
        Branch_taken = 1'b1; Branch_target = 32'd152;
        step(); chk_ifid("to152", 32'h0, 32'h0, 1'b0, 32'd152, 1'b0);
        Branch_taken = 1'b0;
        step(); chk_ifid("f152", 32'hA000_0026, 32'd156, 1'b1, 32'd156, 1'b0);
        step(); chk_ifid("f156", 32'hA000_0027, 32'd160, 1'b1, 32'd160, 1'b0);
        step();
        chk("f160.valid", 32'(IF_ID_Valid), 32'h0);
        chk("f160.instr", IF_ID_Instruction, 32'h0);
        chk("f160.fault", 32'(Fetch_fault), 32'h1);
        chk("f160.ra", Read_address, 32'd160);
        step(); chk("hold160.ra", Read_address, 32'd160);
        chk("hold160.fault", 32'(Fetch_fault), 32'h1);

        // Redirect while faulted: PC moves, fault persists, only bubbles
        Branch_taken = 1'b1; Branch_target = 32'h0;
        step(); chk_ifid("fbr", 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        Branch_taken = 1'b0;
        step(); chk_ifid("fbr2", 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        pulse_reset();
        chk_ifid("rst2", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Misaligned branch target
        step(); chk_ifid("mis0", 32'h2001_0005, 32'd4, 1'b1, 32'd4, 1'b0);
        Branch_taken = 1'b1; Branch_target = 32'h42;
        step(); chk_ifid("mis_br", 32'h0, 32'h0, 1'b0, 32'h42, 1'b0);
        Branch_taken = 1'b0;
        step();
        chk("mis.valid", 32'(IF_ID_Valid), 32'h0);
        chk("mis.fault", 32'(Fetch_fault), 32'h1);
        chk("mis.ra", Read_address, 32'h42);
        pulse_reset();

        // Stall + Flush at PC=20
        for (int i = 0; i < 5; i++) step();
        chk_ifid("pc20", 32'hA000_0004, 32'd20, 1'b1, 32'd20, 1'b0);
        Stall = 1'b1; Flush = 1'b1;
        step(); chk_ifid("stfl", 32'h0, 32'h0, 1'b0, 32'd20, 1'b0);
        Stall = 1'b0; Flush = 1'b0;
        step(); chk_ifid("pc24", 32'hA000_0005, 32'd24, 1'b1, 32'd24, 1'b0);

        // Asynchronous reset mid-cycle, with controls asserted
        Stall = 1'b1; Branch_taken = 1'b1; Branch_target = 32'h80;
        #2 reset_n = 1'b0;
        #1 chk_ifid("async_rst", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        Stall = 1'b0; Branch_taken = 1'b0;
        #10 reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS pipeline, directly upstream of the instruction memory. Holds the program counter, drives the byte address into the instruction memory, and captures the returned 32-bit big-endian instruction word into the IF/ID pipeline register. Supports stall, flush and branch/jump redirect from later stages. Flags out-of-range or misaligned fetches as a sticky fault.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- IMEM_BYTES, 160: instruction memory size in bytes. The highest legal fetch address is IMEM_BYTES-4.

- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Stall  in  1  hold PC and the IF/ID register (hazard unit).
- Flush  in  1  insert a bubble into IF/ID on the next edge.
- Branch_taken  in  1  redirect the PC to Branch_target on the next edge.
- Branch_target  in  32  redirect byte address.
- Read_address  out  32  byte address to the instruction memory; equals the current PC (combinational from the PC register).
- Instruction  in  32  word returned by the instruction memory for Read_address; combinational, same cycle.
- IF_ID_Instruction  out  32  registered instruction.
- IF_ID_PC_plus4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  registered instruction is real (0 = bubble).
- Fetch_fault  out  1  sticky fault flag.

## Operation
- PC register, next-PC mux, IF/ID register, fault flag.
- Next-PC priority, highest first:
  1. Reset.
  2. Branch_taken: PC <= Branch_target. Overrides Stall.
  3. Stall: PC holds.
  4. Fault set: PC holds.
  5. Otherwise: PC <= PC+4.
- PC+4 uses 32-bit modulo arithmetic; carry is discarded. Wrap past IMEM_BYTES is handled by the fault check, not by the adder.
- IF/ID update priority, highest first:
  1. Reset.
  2. Branch_taken or Flush: bubble. Instruction = NOP (32'h0000_0000), PC_plus4 = 0, Valid = 0.
  3. Stall: hold all three fields.
  4. Otherwise: capture Instruction, PC+4 and Valid. Valid = 1 unless the current PC is illegal, in which case Instruction = NOP and Valid = 0.
- Illegal PC: PC[1:0] != 0, or PC > IMEM_BYTES-4.
  - Sets Fetch_fault on the edge where the illegal PC would be captured, i.e. a non-stalled, non-flushed cycle.
  - Fetch_fault clears only on reset.
  - While Fetch_fault = 1, IF/ID receives only bubbles, except that Stall still holds IF/ID.
  - Branch_taken still redirects the PC, but does not clear the fault.
- Stall and Flush together: Flush wins for IF/ID; Stall still holds the PC.

## Timing
- Reset values (asynchronous): PC = RESET_PC, Read_address = RESET_PC, IF_ID_Instruction = 0, IF_ID_PC_plus4 = 0, IF_ID_Valid = 0, Fetch_fault = 0.
- Reset mid-operation: all state returns to the reset values immediately, regardless of Stall, Flush or Branch_taken.
- The first valid IF/ID word appears one edge after reset release; that word is the instruction at RESET_PC.
- Latency from PC to IF/ID is 1 cycle. Branch_taken asserted in cycle n:
  - IF/ID holds a bubble in cycle n+1.
  - The target instruction is valid in IF/ID in cycle n+2.
- Read_address has no register beyond the PC. Memory read is combinational, so the IF/ID capture meets single-edge timing.
- Control inputs are sampled only at the rising edge. No combinational path exists from Stall, Flush or Branch_taken to Read_address.

## Structure
- Shared package `mips_pkg`: NOP_INSTR (32'h0), WORD_BYTES (4), default RESET_PC.
- Sub-module `if_id_reg`: the IF/ID register, with inputs for capture, hold and bubble. It is reused later for the ID/EX pattern.
- The PC, next-PC mux and fault logic stay in `if_stage`.

## Test plan
- Reset with RESET_PC = 0, memory words 0x2001_0005 at address 0 and 0x2002_000A at address 4, no stalls.
  - Cycle 1: IF_ID_Instruction = 0x2001_0005, PC_plus4 = 4, Valid = 1.
  - Cycle 2: 0x2002_000A, PC_plus4 = 8, Valid = 1.
- Stall held 2 cycles at PC = 8: Read_address stays 8 and IF/ID is unchanged for both cycles. On release, PC advances to 12.
- Branch_taken with Branch_target = 0x40 at PC = 16:
  - Next cycle: Read_address = 0x40, IF/ID is a bubble (Valid = 0).
  - Following cycle: the instruction at 0x40 is in IF/ID with PC_plus4 = 0x44.
- Sequential run past address 156 with IMEM_BYTES = 160:
  - Fetch at 156 is valid.
  - At PC = 160: Fetch_fault = 1, Valid = 0, PC holds at 160.
  - A later Branch_taken to 0 moves the PC but Fault stays 1 until reset_n pulses low.
- Branch_target = 0x42 (misaligned): the next capture is a bubble and Fetch_fault = 1.
- Stall + Flush asserted together at PC = 20: PC holds at 20 and IF/ID becomes a bubble. Then assert reset_n = 0 mid-cycle: all outputs go to reset values without waiting for clk.
